obj_line_buffer: RTL and testbench
==================================

OBJ_LINE_BUFFER -- requirements
Module: obj_line_buffer

Interface
REQ-001 SHALL take parameter XW, default 9, as the line x-address width; each bank holds 2^XW pixels.
REQ-002 SHALL take parameter PW, default 4, as the pixel/pen width.
REQ-003 SHALL take parameter TRANSP, default all-ones (4'hF at PW=4), as the transparent pen value.
REQ-004 SHALL take parameter FIRST_WINS, default 1: 1 = first opaque write to an x keeps the pixel; 0 = last opaque write overwrites.
REQ-005 SHALL take parameter PIX_BUDGET, default 0, as the maximum opaque pixels written per line; 0 = unlimited.
REQ-006 pclk  in  1  single clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 line_start  in  1  one-cycle strobe that swaps the write and display banks.
REQ-009 wr_valid  in  1  sprite pixel write request.
REQ-010 wr_ready  out  1  write accepted when wr_valid and wr_ready are both high.
REQ-011 wr_x  in  XW  write x position; wraps modulo 2^XW.
REQ-012 wr_pix  in  PW  pen to write.
REQ-013 rd_en  in  1  display read request.
REQ-014 rd_x  in  XW  display read x.
REQ-015 rd_pix  out  PW  registered read data.
REQ-016 rd_valid  out  1  qualifies rd_pix.
REQ-017 wbank  out  1  current write bank; the display bank is ~wbank.
REQ-018 budget_hit  out  1  sticky for the current line once PIX_BUDGET opaque pixels have been written.

Function
REQ-019 SHALL have an FSM with states INIT and RUN; reset enters INIT.
REQ-020 INIT: SHALL sweep a counter 0..2^XW-1, writing TRANSP to both banks at each count; SHALL enter RUN after the final count; total duration 2^XW cycles.
REQ-021 INIT: wr_ready=0; line_start SHALL be ignored; rd_valid SHALL follow rd_en delayed by 1 cycle, with rd_pix=TRANSP.
REQ-022 RUN: wr_ready SHALL be 1 unless budget_hit=1.
REQ-023 Write pipeline stage 1 (accept): SHALL latch x, pix and the bank at acceptance, then read the target location.
REQ-024 Write pipeline stage 2, cycle after accept: SHALL write pix if pix!=TRANSP and either FIRST_WINS=0 or the stored value==TRANSP; throughput 1 write/cycle.
REQ-025 Back-to-back writes to the same x and bank SHALL forward the stage-2 result into the stage-1 compare, giving results identical to serial execution.
REQ-026 A TRANSP write SHALL be accepted, SHALL modify nothing, and SHALL NOT count toward the budget.
REQ-027 Budget: the counter SHALL increment on each opaque pixel actually stored; budget_hit SHALL set when count==PIX_BUDGET (PIX_BUDGET>0 only).
REQ-028 Budget: budget_hit SHALL clear, and the counter SHALL return to 0, on line_start.
REQ-029 Read: on rd_en, rd_pix SHALL be display[rd_x] on the next cycle, with rd_valid=1 that cycle and 0 otherwise.
REQ-030 Read: in the same cycle as the read, the location SHALL be written TRANSP (clear-behind-read), with old-data-before-clear semantics.
REQ-031 line_start in RUN SHALL toggle wbank on the next edge.
REQ-032 A write in stage 2 at the swap SHALL complete into its latched bank.
REQ-033 A write accepted in the same cycle as line_start SHALL target the old bank.
REQ-034 rd_en coincident with line_start SHALL read the pre-swap display bank.
REQ-035 Reads and writes SHALL never target the same bank, except for the late writes of REQ-032/033, which may land in the new display bank.
REQ-036 wr_x+N overflow is the caller's concern; addresses SHALL wrap silently with no flag.

Reset
REQ-037 On reset=1, these SHALL hold on the next edge: state=INIT, init counter=0, wbank=0, rd_valid=0, rd_pix=TRANSP, wr_ready=0, budget_hit=0, budget counter=0, pipeline valid=0.
REQ-038 Reset asserted mid-line or mid-INIT SHALL restart INIT from 0.
REQ-039 An accepted write still in the pipeline at reset SHALL be dropped.

Verification
REQ-040 Reset, then count cycles until wr_ready=1 -> exactly 512 at XW=9; reading all 512 x of both banks returns 4'hF.
REQ-041 FIRST_WINS=1: write x=10 pen 3, then x=10 pen 7 back-to-back, line_start, read x=10 -> 3; read x=10 again -> 4'hF (cleared).
REQ-042 FIRST_WINS=0, same stimulus as REQ-041 -> read returns 7.
REQ-043 PIX_BUDGET=4: write 6 opaque pixels plus one TRANSP at x=0..6 -> wr_ready drops after the 4th opaque store; only 4 locations non-TRANSP after swap; budget_hit clears on the next line_start.
REQ-044 Assert line_start in the same cycle as accepting x=100 pen 2 -> after a second line_start the pixel appears at x=100 of the display bank; the new write bank's x=100 is unchanged.
REQ-045 Assert reset 3 cycles into a write burst -> no write lands; INIT reruns in full; wbank=0.

Source files
------------

// File: rtl/obj_line_buffer.sv
// Double-banked sprite line buffer. Sprites are written into one bank while the
// other bank is read out for display and cleared behind the read.
module obj_line_buffer #(
  parameter int              XW         = 9,
  parameter int              PW         = 4,
  parameter logic [PW-1:0]   TRANSP     = '1,
  parameter int              FIRST_WINS = 1,
  parameter int              PIX_BUDGET = 0
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          line_start,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [XW-1:0] wr_x,
  input  logic [PW-1:0] wr_pix,
  input  logic          rd_en,
  input  logic [XW-1:0] rd_x,
  output logic [PW-1:0] rd_pix,
  output logic          rd_valid,
  output logic          wbank,
  output logic          budget_hit
);

  localparam int          DEPTH  = 1 << XW;
  localparam logic [31:0] BUDGET = 32'(PIX_BUDGET);

  typedef enum logic [0:0] {INIT, RUN} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] init_cnt_q, init_cnt_d;
  logic          wbank_q, wbank_d;
  logic [31:0]   bcnt_q, bcnt_d;

  // Write pipeline: stage-1 registers hold the accepted request while the
  // target location is being read; stage 2 decides and stores.
  logic          s_valid_q, s_valid_d;
  logic [XW-1:0] s_x_q, s_x_d;
  logic [PW-1:0] s_pix_q, s_pix_d;
  logic          s_bank_q, s_bank_d;
  logic          fwd_q, fwd_d;
  logic [PW-1:0] fwd_pix_q, fwd_pix_d;

  logic          rd_valid_q, rd_valid_d;
  logic          rd_transp_q, rd_transp_d;
  logic          rd_bank_q, rd_bank_d;

  logic                 run;
  logic                 hit;
  logic                 accept;
  logic [PW-1:0]        stored_pix;
  logic                 s2_store;
  logic [1:0][PW-1:0]   bank_cmp;
  logic [1:0][PW-1:0]   bank_disp;

  assign run = (state_q == RUN);
  assign hit = (PIX_BUDGET > 0) && (bcnt_q == BUDGET);

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    wbank_d     = wbank_q;
    bcnt_d      = bcnt_q;
    s_valid_d   = 1'b0;
    s_x_d       = s_x_q;
    s_pix_d     = s_pix_q;
    s_bank_d    = s_bank_q;
    fwd_d       = 1'b0;
    fwd_pix_d   = s_pix_q;
    rd_valid_d  = rd_en;
    rd_transp_d = rd_transp_q;
    rd_bank_d   = rd_bank_q;
    wr_ready    = run && !hit;
    accept      = wr_valid && run && !hit;
    stored_pix  = fwd_q ? fwd_pix_q : bank_cmp[s_bank_q];
    s2_store    = s_valid_q && (s_pix_q != TRANSP) &&
                  ((FIRST_WINS == 0) || (stored_pix == TRANSP)) &&
                  ((PIX_BUDGET == 0) || (bcnt_q < BUDGET));

    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (&init_cnt_q) begin
        state_d = RUN;
      end
    end else begin
      if (s2_store) begin
        bcnt_d = bcnt_q + 32'd1;
      end
      if (accept) begin
        s_valid_d = 1'b1;
        s_x_d     = wr_x;
        s_pix_d   = wr_pix;
        s_bank_d  = wbank_q;
        // The stage-2 store lands on the same edge the new request reads RAM,
        // so the RAM read is stale; substitute the value being stored.
        fwd_d     = s2_store && (s_bank_q == wbank_q) && (s_x_q == wr_x);
      end
      if (line_start) begin
        wbank_d = ~wbank_q;
        bcnt_d  = 32'd0;
      end
    end

    if (rd_en) begin
      rd_transp_d = !run;
      rd_bank_d   = ~wbank_q;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      wbank_q     <= 1'b0;
      bcnt_q      <= 32'd0;
      s_valid_q   <= 1'b0;
      s_x_q       <= '0;
      s_pix_q     <= TRANSP;
      s_bank_q    <= 1'b0;
      fwd_q       <= 1'b0;
      fwd_pix_q   <= TRANSP;
      rd_valid_q  <= 1'b0;
      rd_transp_q <= 1'b1;
      rd_bank_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      wbank_q     <= wbank_d;
      bcnt_q      <= bcnt_d;
      s_valid_q   <= s_valid_d;
      s_x_q       <= s_x_d;
      s_pix_q     <= s_pix_d;
      s_bank_q    <= s_bank_d;
      fwd_q       <= fwd_d;
      fwd_pix_q   <= fwd_pix_d;
      rd_valid_q  <= rd_valid_d;
      rd_transp_q <= rd_transp_d;
      rd_bank_q   <= rd_bank_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [PW-1:0] mem_q [DEPTH];
    logic [PW-1:0] cmp_q;
    logic [PW-1:0] disp_q;
    logic          we_a;
    logic [XW-1:0] addr_a;
    logic [PW-1:0] data_a;
    logic          we_b;

    always_comb begin
      we_a   = 1'b0;
      addr_a = s_x_q;
      data_a = s_pix_q;
      if (state_q == INIT) begin
        we_a   = 1'b1;
        addr_a = init_cnt_q;
        data_a = TRANSP;
      end else if (s2_store && (s_bank_q == 1'(gi))) begin
        we_a = 1'b1;
      end
      we_b = run && rd_en && (wbank_q != 1'(gi));
    end

    // Clear-behind-read is applied after the pipeline store so the display
    // location always ends up transparent once it has been shown.
    always_ff @(posedge pclk) begin
      cmp_q <= mem_q[wr_x];
      if (rd_en) begin
        disp_q <= mem_q[rd_x];
      end
      if (!reset) begin
        if (we_a) begin
          mem_q[addr_a] <= data_a;
        end
        if (we_b) begin
          mem_q[rd_x] <= TRANSP;
        end
      end
    end

    assign bank_cmp[gi]  = cmp_q;
    assign bank_disp[gi] = disp_q;
  end

  assign rd_pix     = rd_transp_q ? TRANSP : bank_disp[rd_bank_q];
  assign rd_valid   = rd_valid_q;
  assign wbank      = wbank_q;
  assign budget_hit = hit;

endmodule

// File: tb/tb_obj_line_buffer.sv
// Three line buffers (first-wins, last-wins, first-wins with budget 4) share one
// stimulus stream; each is checked against a per-instance array model.
module tb_obj_line_buffer;

  localparam int         XW    = 9;
  localparam int         PW    = 4;
  localparam int         N     = 3;
  localparam int         DEPTH = 512;
  localparam logic [3:0] T     = 4'hF;

  logic          pclk = 1'b0;
  logic          reset = 1'b0;
  logic          line_start = 1'b0;
  logic          wr_valid = 1'b0;
  logic          rd_en = 1'b0;
  logic [XW-1:0] wr_x = '0;
  logic [XW-1:0] rd_x = '0;
  logic [PW-1:0] wr_pix = '0;

  logic [N-1:0]         wr_ready_w, rd_valid_w, wbank_w, budget_hit_w;
  logic [N-1:0][PW-1:0] rd_pix_w;

  always #5 pclk = ~pclk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    obj_line_buffer #(
      .XW(XW), .PW(PW), .TRANSP(T),
      .FIRST_WINS((gi == 1) ? 0 : 1),
      .PIX_BUDGET((gi == 2) ? 4 : 0)
    ) u_dut (
      .pclk(pclk), .reset(reset), .line_start(line_start),
      .wr_valid(wr_valid), .wr_ready(wr_ready_w[gi]), .wr_x(wr_x), .wr_pix(wr_pix),
      .rd_en(rd_en), .rd_x(rd_x), .rd_pix(rd_pix_w[gi]), .rd_valid(rd_valid_w[gi]),
      .wbank(wbank_w[gi]), .budget_hit(budget_hit_w[gi])
    );
  end

  int         fw_k  [N] = '{1, 0, 1};
  int         bud_k [N] = '{0, 0, 4};
  logic [3:0] m_mem [N][2][DEPTH];
  int         m_cnt [N];
  bit         m_run [N];
  int         m_init_left [N];
  bit         m_wbank [N];
  bit         m_pend [N];
  bit         m_pbank [N];
  int         m_px [N];
  logic [3:0] m_ppix [N];
  bit         m_known = 1'b0;

  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];
  logic [3:0] exp_q2[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d got=%0h expected=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input int k, input logic [3:0] v);
    case (k)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [3:0] pop_exp(input int k);
    case (k)
      0: return exp_q0.pop_front();
      1: return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  // Applies one clock edge of the current inputs to the model of every instance.
  task automatic model_edge();
    bit         hit, rdy, saw_reset;
    logic [3:0] rv, st;
    saw_reset = reset;
    for (int k = 0; k < N; k++) begin
      hit = (bud_k[k] > 0) && (m_cnt[k] == bud_k[k]);
      rdy = m_run[k] && !hit;
      if (m_known) begin
        chk("wr_ready", k, wr_ready_w[k], rdy);
        chk("budget_hit", k, budget_hit_w[k], hit);
        chk("wbank", k, wbank_w[k], m_wbank[k]);
      end
      if (reset) begin
        for (int b = 0; b < 2; b++)
          for (int x = 0; x < DEPTH; x++) m_mem[k][b][x] = T;
        m_cnt[k] = 0; m_run[k] = 1'b0; m_init_left[k] = DEPTH;
        m_wbank[k] = 1'b0; m_pend[k] = 1'b0;
      end else if (!m_run[k]) begin
        if (rd_en) push_exp(k, T);
        m_init_left[k]--;
        if (m_init_left[k] == 0) m_run[k] = 1'b1;
      end else begin
        rv = m_mem[k][!m_wbank[k]][rd_x];
        if (m_pend[k]) begin
          st = m_mem[k][m_pbank[k]][m_px[k]];
          if (m_ppix[k] != T && (fw_k[k] == 0 || st == T) && (bud_k[k] == 0 || m_cnt[k] < bud_k[k])) begin
            m_mem[k][m_pbank[k]][m_px[k]] = m_ppix[k];
            m_cnt[k]++;
          end
        end
        if (rd_en) begin
          push_exp(k, rv);
          m_mem[k][!m_wbank[k]][rd_x] = T;
        end
        m_pend[k] = wr_valid && rdy;
        if (m_pend[k]) begin
          m_pbank[k] = m_wbank[k]; m_px[k] = int'(wr_x); m_ppix[k] = wr_pix;
        end
        if (line_start) begin
          m_wbank[k] = !m_wbank[k];
          m_cnt[k] = 0;
        end
      end
    end
    if (saw_reset) m_known = 1'b1;
  endtask

  task automatic tick();
    model_edge();
    @(negedge pclk);
  endtask

  task automatic idle(input int n);
    wr_valid = 1'b0; rd_en = 1'b0; line_start = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wr(input int x, input logic [3:0] p);
    wr_valid = 1'b1; wr_x = XW'(x); wr_pix = p;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input int x);
    rd_en = 1'b1; rd_x = XW'(x);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic swap();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
  endtask

  task automatic read_all();
    for (int x = 0; x < DEPTH; x++) rd(x);
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (wr_ready_w[0] !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk("init_cycles", 0, n, DEPTH);
  endtask

  // Scoreboard monitor: every rd_valid consumes one expected pixel.
  always @(negedge pclk) begin
    if (m_known) begin
      for (int k = 0; k < N; k++) begin
        if (rd_valid_w[k] === 1'b1) begin
          if (qsize(k) == 0) begin
            chk("rd_unexpected", k, 32'd1, 32'd0);
          end else begin
            chk("rd_pix", k, rd_pix_w[k], pop_exp(k));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge pclk);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("rst_rd_valid", k, rd_valid_w[k], 0);
      chk("rst_rd_pix", k, rd_pix_w[k], T);
    end

    // Partial INIT with ignored writes/line_start and transparent reads, then reset again.
    for (int c = 0; c < 100; c++) begin
      wr_valid = $urandom_range(0, 1); wr_x = XW'($urandom); wr_pix = PW'($urandom);
      rd_en = $urandom_range(0, 1); rd_x = XW'($urandom);
      line_start = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_init();

    read_all();
    swap();
    read_all();

    // Back-to-back same-x writes: first-wins keeps 3, last-wins keeps 7.
    wr(10, 4'd3);
    wr(10, 4'd7);
    idle(2);
    swap();
    rd(10);
    rd(10);
    idle(2);

    // Budget: six opaque pens and one transparent at x=0..6.
    wr(0, 4'd1); wr(1, 4'd2); wr(2, T); wr(3, 4'd3); wr(4, 4'd4); wr(5, 4'd5); wr(6, 4'd6);
    idle(3);
    swap();
    for (int x = 0; x < 8; x++) rd(x);
    idle(2);

    // Write accepted together with line_start goes to the old write bank.
    wr_valid = 1'b1; wr_x = XW'(100); wr_pix = 4'd2; line_start = 1'b1;
    tick();
    idle(2);
    rd(100);
    idle(1);
    swap();
    rd(100);
    idle(2);

    // Random lines with collisions, repeated x and transparent pens.
    for (int ln = 0; ln < 6; ln++) begin
      for (int c = 0; c < 60; c++) begin
        wr_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) != 0) wr_x = XW'($urandom_range(0, 31));
        wr_pix = ($urandom_range(0, 4) == 0) ? T : PW'($urandom_range(0, 14));
        rd_en = $urandom_range(0, 1);
        rd_x = XW'($urandom_range(0, 40));
        tick();
      end
      idle(2);
      swap();
    end

    // Reset three cycles into a write burst.
    wr(200, 4'd1); wr(201, 4'd2); wr(202, 4'd3);
    wr_valid = 1'b1; wr_x = XW'(203); wr_pix = 4'd4; reset = 1'b1;
    tick();
    reset = 1'b0; wr_valid = 1'b0;
    for (int k = 0; k < N; k++) chk("rst_wbank", k, wbank_w[k], 0);
    wait_init();
    read_all();
    swap();
    read_all();

    idle(3);
    for (int k = 0; k < N; k++) chk("rd_outstanding", k, qsize(k), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
